// File: rtl/mdu.sv
// mdu: EX-stage multiply/divide unit that owns the HI/LO register pair.
//
// Operations (MDUCtrl, qualified by En):
//   000 mult   001 multu   010 div   011 divu
//   100 mfhi   101 mthi    110 mflo  111 mtlo
//
// mult/multu/div/divu compute their 64-bit result in the cycle they start.
// The result is held in pending registers and committed to HI/LO after a
// fixed busy period of MULT_CYCLES or DIV_CYCLES cycles. Busy stays high
// for exactly that many cycles.
//
// Handshake: a start, mthi or mtlo is accepted only on an edge where
// En=1 and the registered Busy is 0. Anything presented while Busy=1 is
// dropped without side effects; the hazard unit is expected to stall such
// instructions, so dropping them is a safety net, not a queueing mechanism.
// mfhi/mflo are combinational reads of the current HI/LO and never stall
// in here.
//
// Optional build macro MDU_DIVZERO_EN adds a registered DivZero output
// that pulses for one cycle on the commit edge of a div/divu with B=0.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        En,
  input  logic [2:0]  MDUCtrl,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] Out,
`ifdef MDU_DIVZERO_EN
  output logic        Busy,
  output logic        DivZero
`else
  output logic        Busy
`endif
);

  // Busy-period lengths, held in the 4-bit counter width.
  localparam logic [3:0] LP_MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] LP_DIV_CNT  = 4'(DIV_CYCLES);

  localparam logic [2:0] OP_MFHI = 3'b100;
  localparam logic [2:0] OP_MTHI = 3'b101;
  localparam logic [2:0] OP_MTLO = 3'b111;

  // Architectural and pending state.
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_pend_hi;
  logic [31:0] r_pend_lo;
  logic        r_pend_divzero;
  logic [3:0]  r_cnt;
  logic        r_busy;

  // Decode.
  logic        w_is_arith;
  logic        w_is_div;
  logic        w_is_unsigned;
  logic        w_start;
  logic        w_mthi;
  logic        w_mtlo;
  logic        w_last;

  // Multiplier datapath.
  logic [63:0] w_a_ext;
  logic [63:0] w_b_ext;
  logic [63:0] w_prod;

  // Divider datapath (sign/magnitude around an unsigned core).
  logic        w_a_neg;
  logic        w_b_neg;
  logic        w_b_zero;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_b_div;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  logic [63:0] w_result;

  // Decode the operation and the acceptance conditions.
  always_comb begin
    w_is_arith    = ~MDUCtrl[2];
    w_is_div      = MDUCtrl[1];
    w_is_unsigned = MDUCtrl[0];
    w_start       = En & w_is_arith & ~r_busy;
    w_mthi        = En & (MDUCtrl == OP_MTHI) & ~r_busy;
    w_mtlo        = En & (MDUCtrl == OP_MTLO) & ~r_busy;
    // Final busy cycle; a counter of 0 while busy is treated as final so
    // the unit can never get stuck.
    w_last        = r_busy & (r_cnt <= 4'd1);
  end

  // Multiply: sign- or zero-extend to 64 bits; the low 64 bits of the
  // product are then correct for both signed and unsigned operands.
  always_comb begin
    w_a_ext = {{32{A[31] & ~w_is_unsigned}}, A};
    w_b_ext = {{32{B[31] & ~w_is_unsigned}}, B};
    w_prod  = w_a_ext * w_b_ext;
  end

  // Divide: unsigned divide on magnitudes, then restore signs. The
  // quotient truncates toward zero and the remainder follows the dividend.
  // 0x80000000 / -1 falls out naturally: the magnitude 0x80000000 divided
  // by 1 negates back to 0x80000000 with remainder 0.
  always_comb begin
    w_a_neg  = A[31] & ~w_is_unsigned;
    w_b_neg  = B[31] & ~w_is_unsigned;
    w_b_zero = (B == 32'd0);
    w_a_mag  = w_a_neg ? (32'd0 - A) : A;
    w_b_mag  = w_b_neg ? (32'd0 - B) : B;
    // Divisor forced to 1 on divide-by-zero; that result is never committed.
    w_b_div  = w_b_zero ? 32'd1 : w_b_mag;
    w_q_mag  = w_a_mag / w_b_div;
    w_r_mag  = w_a_mag % w_b_div;
    w_quot   = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
    w_rem    = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;
  end

  // Select the 64-bit {HI,LO} result for the operation being started.
  always_comb begin
    w_result = w_is_div ? {w_rem, w_quot} : w_prod;
  end

  // Busy period control: capture the pending result at start, count down,
  // and drop Busy on the edge that ends the last busy cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy         <= 1'b0;
      r_cnt          <= 4'd0;
      r_pend_hi      <= 32'd0;
      r_pend_lo      <= 32'd0;
      r_pend_divzero <= 1'b0;
    end else if (r_busy) begin
      if (r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_last) begin
        r_busy <= 1'b0;
        r_cnt  <= 4'd0;
      end
    end else if (w_start) begin
      r_busy         <= 1'b1;
      r_cnt          <= w_is_div ? LP_DIV_CNT : LP_MULT_CNT;
      r_pend_hi      <= w_result[63:32];
      r_pend_lo      <= w_result[31:0];
      r_pend_divzero <= w_is_div & w_b_zero;
    end
  end

  // HI/LO update: commit a finished operation (unless it divided by zero)
  // or take a direct mthi/mtlo write. The two cannot coincide because
  // writes are only accepted while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else if (w_last) begin
      if (!r_pend_divzero) begin
        r_hi <= r_pend_hi;
        r_lo <= r_pend_lo;
      end
    end else begin
      if (w_mthi) begin
        r_hi <= A;
      end
      if (w_mtlo) begin
        r_lo <= A;
      end
    end
  end

`ifdef MDU_DIVZERO_EN
  logic r_divzero;

  // One-cycle divide-by-zero flag raised on the commit edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_divzero <= 1'b0;
    end else begin
      r_divzero <= w_last & r_pend_divzero;
    end
  end

  assign DivZero = r_divzero;
`endif

  // Read port: HI for mfhi, LO for every other code.
  always_comb begin
    Out  = (MDUCtrl == OP_MFHI) ? r_hi : r_lo;
    Busy = r_busy;
  end

endmodule
